// File: rtl/ram_responder.sv
// Purpose: RAM-side responder; accepts a read/write request from ram_ctrl, performs it
//          on an internal word array after wait_cycles wait states, then holds ACK.
// Latency: request sampled at edge T -> access and ACK at edge T+1+wait_cycles.
// Backpressure: one transaction at a time; ACK is held until both request pins read 0,
//               and the next request is accepted no earlier than the following edge.
// Ports:
//   clk, rst         - single clock, asynchronous active-high reset
//   ram_ctrl         - request pins (RAM_READ_PIN, RAM_WRITE_PIN); other bits ignored
//   ram_stat         - status bits RAM_ACK, RAM_BUSY, RAM_ERR; other bits 0
//   addr, data_in    - word address and write data, latched at acceptance
//   data_out         - registered read data, updated only when a read completes
// Optional feature macro: RAM_BOUNDS_EN (out-of-range addresses flag RAM_ERR, no access).

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef RAM_READ_PIN
`define RAM_READ_PIN 0
`endif
`ifndef RAM_WRITE_PIN
`define RAM_WRITE_PIN 1
`endif
`ifndef RAM_ACK
`define RAM_ACK 0
`endif
`ifndef RAM_BUSY
`define RAM_BUSY 1
`endif
`ifndef RAM_ERR
`define RAM_ERR 2
`endif

module ram_responder #(
  parameter int word_width  = `WORD_WIDTH,
  parameter int addr_bits   = 10,
  parameter int wait_cycles = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] ram_ctrl,
  output logic [word_width-1:0] ram_stat,
  input  logic [word_width-1:0] addr,
  input  logic [word_width-1:0] data_in,
  output logic [word_width-1:0] data_out
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [7:0] WAIT_INIT = 8'(wait_cycles);

  state_t                state_q, state_d;
  logic [7:0]            cnt_q;
  logic                  op_wr_q;
  logic [word_width-1:0] addr_q;
  logic [word_width-1:0] data_q;
  logic                  err_q;

  logic wr_pin, rd_pin, req, access, oob, mem_we;
  logic unused_bits;

  logic [word_width-1:0] mem [0:(1<<addr_bits)-1];

  assign wr_pin = ram_ctrl[`RAM_WRITE_PIN];
  assign rd_pin = ram_ctrl[`RAM_READ_PIN];
  assign req    = wr_pin | rd_pin;

  // The access happens on the same edge that moves WAIT -> ACK.
  assign access = (state_q == S_WAIT) && (cnt_q == 8'd0);

`ifdef RAM_BOUNDS_EN
  assign oob = (addr_q >> addr_bits) != '0;
`else
  // Upper address bits are dropped, so addresses wrap modulo the depth.
  assign oob = 1'b0;
`endif

  assign mem_we = access && op_wr_q && !oob && !rst;

  // Unused pin/address bits are intentionally ignored.
  assign unused_bits = ^{ram_ctrl, addr_q};

  // State register plus the datapath registers that move with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      op_wr_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      data_out <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            // Write wins when both pins are set.
            op_wr_q <= wr_pin;
            addr_q  <= addr;
            data_q  <= data_in;
            cnt_q   <= WAIT_INIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            err_q <= oob;
            if (!op_wr_q) begin
              data_out <= oob ? '0 : mem[addr_q[addr_bits-1:0]];
            end
          end
        end
        S_ACK: begin
          if (!req) begin
            err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q[addr_bits-1:0]] <= data_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = S_WAIT;
      S_WAIT:  if (cnt_q == 8'd0) state_d = S_ACK;
      S_ACK:   if (!req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    ram_stat            = '0;
    ram_stat[`RAM_BUSY] = (state_q != S_IDLE);
    ram_stat[`RAM_ACK]  = (state_q == S_ACK);
    ram_stat[`RAM_ERR]  = (state_q == S_ACK) && err_q;
  end

endmodule

// File: tb/tb_ram_responder.sv
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef RAM_READ_PIN
`define RAM_READ_PIN 0
`endif
`ifndef RAM_WRITE_PIN
`define RAM_WRITE_PIN 1
`endif
`ifndef RAM_ACK
`define RAM_ACK 0
`endif
`ifndef RAM_BUSY
`define RAM_BUSY 1
`endif
`ifndef RAM_ERR
`define RAM_ERR 2
`endif

module tb_ram_responder;

  localparam logic [31:0] PIN_R  = 32'd1 << `RAM_READ_PIN;
  localparam logic [31:0] PIN_W  = 32'd1 << `RAM_WRITE_PIN;
  localparam logic [31:0] ST_BSY = 32'd1 << `RAM_BUSY;
  localparam logic [31:0] ST_ACK = ST_BSY | (32'd1 << `RAM_ACK);
  localparam logic [31:0] ST_ERR = ST_ACK | (32'd1 << `RAM_ERR);

  logic        clk, rst;
  logic [31:0] ctrl0, stat0, addr0, din0, dout0;
  logic [31:0] ctrl1, stat1, addr1, din1, dout1;

  int n_chk  = 0;
  int n_fail = 0;

  ram_responder #(.word_width(32), .addr_bits(10), .wait_cycles(2)) u0 (
    .clk(clk), .rst(rst), .ram_ctrl(ctrl0), .ram_stat(stat0),
    .addr(addr0), .data_in(din0), .data_out(dout0)
  );

  ram_responder #(.word_width(32), .addr_bits(10), .wait_cycles(0)) u1 (
    .clk(clk), .rst(rst), .ram_ctrl(ctrl1), .ram_stat(stat1),
    .addr(addr1), .data_in(din1), .data_out(dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full transaction on u0 (wait_cycles=2) with cycle-exact status checks.
  task automatic xact0(input string tag, input logic [31:0] ctrl, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] ack_stat,
                       input logic [31:0] exp_do);
    ctrl0 = ctrl; addr0 = a; din0 = d;
    step;                                   // edge T: accepted
    chk({tag, " busy T"}, stat0, ST_BSY);
    addr0 = a ^ 32'h5; din0 = ~d;           // must be ignored after acceptance
    step;
    chk({tag, " busy T+1"}, stat0, ST_BSY);
    step;
    chk({tag, " busy T+2"}, stat0, ST_BSY);
    step;                                   // edge T+3: access + ACK
    chk({tag, " ack T+3"}, stat0, ack_stat);
    chk({tag, " data_out"}, dout0, exp_do);
    ctrl0 = 32'h0;
    step;
    chk({tag, " drop"}, stat0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    ctrl0 = 0; addr0 = 0; din0 = 0;
    ctrl1 = 0; addr1 = 0; din1 = 0;
    #1;
    chk("reset stat0", stat0, 32'h0);
    chk("reset dout0", dout0, 32'h0);
    chk("reset stat1", stat1, 32'h0);
    step; step;
    rst = 1'b0;
    step;

    // Reset in the middle of WAIT must abort the write.
    xact0("prewrite 010", PIN_W, 32'h010, 32'h11111111, ST_ACK, 32'h0);
    xact0("read 010", PIN_R, 32'h010, 32'h0, ST_ACK, 32'h11111111);
    ctrl0 = PIN_W; addr0 = 32'h010; din0 = 32'hDEADBEEF;
    step;
    chk("abort busy", stat0, ST_BSY);
    step;
    #1 rst = 1'b1;
    #1;
    chk("abort stat", stat0, 32'h0);
    chk("abort dout", dout0, 32'h0);
    ctrl0 = 0;
    step; step;
    rst = 1'b0;
    step;
    xact0("reread 010", PIN_R, 32'h010, 32'h0, ST_ACK, 32'h11111111);

    // Basic write then read.
    xact0("write 005", PIN_W, 32'h005, 32'hCAFEF00D, ST_ACK, 32'h11111111);
    xact0("read 005", PIN_R, 32'h005, 32'h0, ST_ACK, 32'hCAFEF00D);

    // Both pins set: write wins, data_out untouched.
    xact0("both 020", PIN_W | PIN_R, 32'h020, 32'h12345678, ST_ACK, 32'hCAFEF00D);
    xact0("read 020", PIN_R, 32'h020, 32'h0, ST_ACK, 32'h12345678);

    // Pins held through ACK: single access, ACK stays up.
    ctrl0 = PIN_W; addr0 = 32'h030; din0 = 32'h0A0A0A0A;
    step; step; step; step;
    chk("hold ack", stat0, ST_ACK);
    addr0 = 32'h031; din0 = 32'hB0B0B0B0;
    for (int i = 0; i < 10; i++) begin
      step;
      chk("hold ack held", stat0, ST_ACK);
    end
    chk("hold dout", dout0, 32'h12345678);
    ctrl0 = 0;
    step;
    chk("hold drop", stat0, 32'h0);
    ctrl0 = PIN_R; addr0 = 32'h030;
    step;
    chk("hold next accept", stat0, ST_BSY);
    step; step; step;
    chk("hold read ack", stat0, ST_ACK);
    chk("hold read data", dout0, 32'h0A0A0A0A);
    ctrl0 = 0;
    step;
    chk("hold read drop", stat0, 32'h0);

    // Out-of-range address 0x400.
    xact0("write 000", PIN_W, 32'h000, 32'h0BAD0000, ST_ACK, 32'h0A0A0A0A);
`ifdef RAM_BOUNDS_EN
    xact0("read 400", PIN_R, 32'h400, 32'h0, ST_ERR, 32'h0);
`else
    xact0("read 400", PIN_R, 32'h400, 32'h0, ST_ACK, 32'h0BAD0000);
`endif

    // wait_cycles = 0 instance.
    ctrl1 = PIN_W; addr1 = 32'h3FF; din1 = 32'hA5A5A5A5;
    step;
    chk("w0 write busy", stat1, ST_BSY);
    step;
    chk("w0 write ack", stat1, ST_ACK);
    ctrl1 = 0;
    step;
    chk("w0 write drop", stat1, 32'h0);
    ctrl1 = PIN_R;
    step;
    chk("w0 read busy", stat1, ST_BSY);
    step;
    chk("w0 read ack", stat1, ST_ACK);
    chk("w0 read data", dout1, 32'hA5A5A5A5);
    ctrl1 = 0;
    step;
    chk("w0 read drop", stat1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
